// File: rtl/riscv_ex_pkg.sv
// Shared EX-stage types: field widths, EX1 occupancy states and the operand-stage payload.
// Payload fields are sized for RV64; RV32 builds zero-extend into them and truncate on the way out.
package riscv_ex_pkg;

  localparam int REG_ADDR_W   = 5;
  localparam int ALU_OP_W     = 6;
  localparam int FUNCT3_W     = 3;
  localparam int PAYLOAD_XLEN = 64;

  typedef enum logic [1:0] {
    EX1_EMPTY = 2'd0,
    EX1_FULL  = 2'd1,
    EX1_SKID  = 2'd2
  } ex1_state_e;

  typedef struct packed {
    logic [PAYLOAD_XLEN-1:0] pc;
    logic [31:0]             inst;
    logic [PAYLOAD_XLEN-1:0] imm;
    logic [REG_ADDR_W-1:0]   rd;
    logic [ALU_OP_W-1:0]     alu_op;
    logic [FUNCT3_W-1:0]     funct3;
    logic                    is_32bit;
  } ex1_payload_t;

endpackage

// File: rtl/riscv_operand_bypass_mux.sv
// Resolves one source operand: x0 -> 0, else lowest-index matching bypass, else register file.
// Purely combinational, no handshake; sits in front of the EX1 main/skid D-inputs.
module riscv_operand_bypass_mux
  import riscv_ex_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int NUM_BYP = 2
) (
  input  logic [REG_ADDR_W-1:0]         rs_addr,
  input  logic [XLEN-1:0]               rf_data,
  input  logic [NUM_BYP-1:0]            byp_valid,
  input  logic [NUM_BYP*REG_ADDR_W-1:0] byp_rd,
  input  logic [NUM_BYP*XLEN-1:0]       byp_data,
  output logic [XLEN-1:0]               operand
);

  // Walk from oldest to youngest so the lowest index overwrites last and wins.
  always_comb begin
    operand = rf_data;
    for (int j = NUM_BYP - 1; j >= 0; j--) begin
      if (byp_valid[j] && (byp_rd[j*REG_ADDR_W +: REG_ADDR_W] == rs_addr)) begin
        operand = byp_data[j*XLEN +: XLEN];
      end
    end
    if (rs_addr == '0) begin
      operand = '0;
    end
  end

endmodule

// File: rtl/riscv_ex1_operand_stage.sv
// EX1 operand stage: resolves NUM_SRC operands at accept and registers the bundle for EX2, 1-cycle latency.
// Main register plus one skid entry; in_ready is decoded from state only, so out_ready never reaches it combinationally.
module riscv_ex1_operand_stage
  import riscv_ex_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int NUM_SRC = 2,
  parameter int NUM_BYP = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [XLEN-1:0]               in_pc,
  input  logic [31:0]                   in_inst,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] in_rs_addr,
  input  logic [REG_ADDR_W-1:0]         in_rd_addr,
  input  logic [XLEN-1:0]               in_imm,
  input  logic [ALU_OP_W-1:0]           in_alu_op,
  input  logic [FUNCT3_W-1:0]           in_funct3,
  input  logic                          in_is_32bit,
  output logic [NUM_SRC*REG_ADDR_W-1:0] rf_addr,
  input  logic [NUM_SRC*XLEN-1:0]       rf_data,
  input  logic [NUM_BYP-1:0]            byp_valid,
  input  logic [NUM_BYP*REG_ADDR_W-1:0] byp_rd,
  input  logic [NUM_BYP*XLEN-1:0]       byp_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [XLEN-1:0]               out_pc,
  output logic [31:0]                   out_inst,
  output logic [XLEN-1:0]               out_imm,
  output logic [REG_ADDR_W-1:0]         out_rd_addr,
  output logic [ALU_OP_W-1:0]           out_alu_op,
  output logic [FUNCT3_W-1:0]           out_funct3,
  output logic                          out_is_32bit,
  output logic [NUM_SRC*XLEN-1:0]       out_src_data
);

  ex1_state_e               state_q, state_d;
  ex1_payload_t             main_pl_q, main_pl_d, skid_pl_q, skid_pl_d, in_pl;
  logic [NUM_SRC*XLEN-1:0]  main_src_q, main_src_d, skid_src_q, skid_src_d, in_src;
  logic                     accept;

  assign rf_addr = in_rs_addr;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    riscv_operand_bypass_mux #(
      .XLEN    (XLEN),
      .NUM_BYP (NUM_BYP)
    ) u_byp_mux (
      .rs_addr   (in_rs_addr[g*REG_ADDR_W +: REG_ADDR_W]),
      .rf_data   (rf_data[g*XLEN +: XLEN]),
      .byp_valid (byp_valid),
      .byp_rd    (byp_rd),
      .byp_data  (byp_data),
      .operand   (in_src[g*XLEN +: XLEN])
    );
  end

  always_comb begin
    in_pl          = '0;
    in_pl.pc       = PAYLOAD_XLEN'(in_pc);
    in_pl.inst     = in_inst;
    in_pl.imm      = PAYLOAD_XLEN'(in_imm);
    in_pl.rd       = in_rd_addr;
    in_pl.alu_op   = in_alu_op;
    in_pl.funct3   = in_funct3;
    in_pl.is_32bit = in_is_32bit;
  end

  assign in_ready  = (state_q != EX1_SKID);
  assign out_valid = (state_q != EX1_EMPTY);
  assign accept    = in_valid & in_ready & ~flush;

  always_comb begin
    state_d    = state_q;
    main_pl_d  = main_pl_q;
    main_src_d = main_src_q;
    skid_pl_d  = skid_pl_q;
    skid_src_d = skid_src_q;
    unique case (state_q)
      EX1_EMPTY: begin
        if (accept) begin
          state_d    = EX1_FULL;
          main_pl_d  = in_pl;
          main_src_d = in_src;
        end
      end
      EX1_FULL: begin
        if (out_ready) begin
          state_d = accept ? EX1_FULL : EX1_EMPTY;
          if (accept) begin
            main_pl_d  = in_pl;
            main_src_d = in_src;
          end
        end else if (accept) begin
          state_d    = EX1_SKID;
          skid_pl_d  = in_pl;
          skid_src_d = in_src;
        end
      end
      EX1_SKID: begin
        if (out_ready) begin
          state_d    = EX1_FULL;
          main_pl_d  = skid_pl_q;
          main_src_d = skid_src_q;
        end
      end
      default: state_d = EX1_EMPTY;
    endcase
    // Flush overrides whatever the handshake decided; stale data is harmless once invalid.
    if (flush) begin
      state_d = EX1_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EX1_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    main_pl_q  <= main_pl_d;
    main_src_q <= main_src_d;
    skid_pl_q  <= skid_pl_d;
    skid_src_q <= skid_src_d;
  end

  assign out_pc       = main_pl_q.pc[XLEN-1:0];
  assign out_inst     = main_pl_q.inst;
  assign out_imm      = main_pl_q.imm[XLEN-1:0];
  assign out_rd_addr  = main_pl_q.rd;
  assign out_alu_op   = main_pl_q.alu_op;
  assign out_funct3   = main_pl_q.funct3;
  assign out_is_32bit = main_pl_q.is_32bit;
  assign out_src_data = main_src_q;

endmodule

// File: tb/tb_riscv_ex1_operand_stage.sv
// Bench for the EX1 operand stage: vector table, directed handshake sequences and random traffic vs a queue model.
module tb_riscv_ex1_operand_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush, in_valid, in_ready, out_ready, out_valid;
  logic [63:0] in_pc, in_imm, out_pc, out_imm;
  logic [31:0] in_inst, out_inst;
  logic [9:0] in_rs_addr, rf_addr, byp_rd;
  logic [4:0] in_rd_addr, out_rd_addr;
  logic [5:0] in_alu_op, out_alu_op;
  logic [2:0] in_funct3, out_funct3;
  logic in_is_32bit, out_is_32bit;
  logic [127:0] rf_data, byp_data, out_src_data;
  logic [1:0] byp_valid;

  riscv_ex1_operand_stage #(.XLEN(64), .NUM_SRC(2), .NUM_BYP(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_rs_addr(in_rs_addr), .in_rd_addr(in_rd_addr),
    .in_imm(in_imm), .in_alu_op(in_alu_op), .in_funct3(in_funct3), .in_is_32bit(in_is_32bit),
    .rf_addr(rf_addr), .rf_data(rf_data), .byp_valid(byp_valid), .byp_rd(byp_rd),
    .byp_data(byp_data), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .out_imm(out_imm), .out_rd_addr(out_rd_addr), .out_alu_op(out_alu_op),
    .out_funct3(out_funct3), .out_is_32bit(out_is_32bit), .out_src_data(out_src_data)
  );

  // Second instance: RV32, three sources.
  logic b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_is32, b_out_is32;
  logic [31:0] b_pc, b_imm, b_inst, b_out_pc, b_out_imm, b_out_inst;
  logic [14:0] b_rs, b_rf_addr;
  logic [4:0] b_rd, b_out_rd;
  logic [5:0] b_op, b_out_op;
  logic [2:0] b_f3, b_out_f3;
  logic [95:0] b_rf_data, b_src;
  logic [1:0] b_byp_valid;
  logic [9:0] b_byp_rd;
  logic [63:0] b_byp_data;

  riscv_ex1_operand_stage #(.XLEN(32), .NUM_SRC(3), .NUM_BYP(2)) dut32 (
    .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_pc(b_pc), .in_inst(b_inst), .in_rs_addr(b_rs), .in_rd_addr(b_rd),
    .in_imm(b_imm), .in_alu_op(b_op), .in_funct3(b_f3), .in_is_32bit(b_is32),
    .rf_addr(b_rf_addr), .rf_data(b_rf_data), .byp_valid(b_byp_valid), .byp_rd(b_byp_rd),
    .byp_data(b_byp_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pc(b_out_pc),
    .out_inst(b_out_inst), .out_imm(b_out_imm), .out_rd_addr(b_out_rd), .out_alu_op(b_out_op),
    .out_funct3(b_out_f3), .out_is_32bit(b_out_is32), .out_src_data(b_src)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference model: a FIFO of at most two accepted bundles; head is what EX2 sees.
  typedef struct {
    logic [63:0]  pc;
    logic [31:0]  inst;
    logic [63:0]  imm;
    logic [4:0]   rd;
    logic [5:0]   op;
    logic [2:0]   f3;
    logic         w;
    logic [127:0] src;
  } ent_t;
  ent_t q[$];

  function automatic logic [63:0] resolve(input int i);
    logic [4:0] rs;
    rs = in_rs_addr[5*i +: 5];
    if (rs == 5'd0) return 64'd0;
    for (int j = 0; j < 2; j++)
      if (byp_valid[j] && byp_rd[5*j +: 5] == rs) return byp_data[64*j +: 64];
    return rf_data[64*i +: 64];
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".out_valid"}, 128'(out_valid), 128'(q.size() > 0));
    chk({tag, ".in_ready"}, 128'(in_ready), 128'(q.size() < 2));
    if (q.size() > 0) begin
      chk({tag, ".pc"}, 128'(out_pc), 128'(q[0].pc));
      chk({tag, ".inst"}, 128'(out_inst), 128'(q[0].inst));
      chk({tag, ".imm"}, 128'(out_imm), 128'(q[0].imm));
      chk({tag, ".ctl"}, 128'({out_rd_addr, out_alu_op, out_funct3, out_is_32bit}),
          128'({q[0].rd, q[0].op, q[0].f3, q[0].w}));
      chk({tag, ".src"}, out_src_data, q[0].src);
    end
  endtask

  task automatic rand_payload();
    in_pc = {$urandom, $urandom};
    in_inst = $urandom;
    in_imm = {$urandom, $urandom};
    in_rd_addr = 5'($urandom);
    in_alu_op = 6'($urandom);
    in_funct3 = 3'($urandom);
    in_is_32bit = 1'($urandom);
  endtask

  task automatic cycle(input string tag);
    ent_t e;
    logic acc;
    acc = in_valid && (q.size() < 2) && !flush;
    e.pc = in_pc; e.inst = in_inst; e.imm = in_imm; e.rd = in_rd_addr;
    e.op = in_alu_op; e.f3 = in_funct3; e.w = in_is_32bit;
    e.src = {resolve(1), resolve(0)};
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    #1;
    check_model(tag);
  endtask

  typedef struct {
    logic [9:0]   rs;
    logic [1:0]   bv;
    logic [9:0]   brd;
    logic [127:0] bdata;
    logic [127:0] rf;
    logic [127:0] exp;
  } vec_t;
  vec_t vt[5];

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_inst = '0; in_imm = '0; in_rd_addr = '0; in_alu_op = '0;
    in_funct3 = '0; in_is_32bit = 1'b0; in_rs_addr = '0; rf_data = '0;
    byp_valid = '0; byp_rd = '0; byp_data = '0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1; b_pc = '0; b_imm = '0;
    b_inst = '0; b_rs = '0; b_rd = '0; b_op = '0; b_f3 = '0; b_is32 = 1'b0;
    b_rf_data = '0; b_byp_valid = '0; b_byp_rd = '0; b_byp_data = '0;

    vt[0] = '{rs:{5'd3,5'd5}, bv:2'b11, brd:{5'd5,5'd5}, bdata:{64'hAA,64'hBB},
              rf:{64'h1003,64'h1005}, exp:{64'h1003,64'hBB}};
    vt[1] = '{rs:{5'd0,5'd0}, bv:2'b01, brd:{5'd9,5'd0}, bdata:{64'h66,64'h77},
              rf:{64'h88,64'h99}, exp:{64'h0,64'h0}};
    vt[2] = '{rs:{5'd3,5'd7}, bv:2'b10, brd:{5'd7,5'd3}, bdata:{64'h11,64'h22},
              rf:{64'h2003,64'h33}, exp:{64'h2003,64'h11}};
    vt[3] = '{rs:{5'd7,5'd7}, bv:2'b00, brd:{5'd7,5'd7}, bdata:{64'h1,64'h2},
              rf:{64'h3007,64'h33}, exp:{64'h3007,64'h33}};
    vt[4] = '{rs:{5'd4,5'd9}, bv:2'b11, brd:{5'd9,5'd4}, bdata:{64'h44,64'h55},
              rf:{64'h4004,64'h4009}, exp:{64'h55,64'h44}};

    #2;
    chk("reset.out_valid", 128'(out_valid), 128'd0);
    chk("reset.in_ready", 128'(in_ready), 128'd1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    check_model("post_reset");

    // Back-to-back stream with EX2 always ready.
    for (int k = 0; k < 4; k++) begin
      rand_payload(); in_rs_addr = 10'($urandom); rf_data = {$urandom, $urandom, $urandom, $urandom};
      in_valid = 1'b1;
      cycle("stream");
    end
    in_valid = 1'b0;
    cycle("stream_drain");

    // Operand resolution vectors.
    foreach (vt[k]) begin
      rand_payload();
      in_rs_addr = vt[k].rs; byp_valid = vt[k].bv; byp_rd = vt[k].brd;
      byp_data = vt[k].bdata; rf_data = vt[k].rf; in_valid = 1'b1;
      #1;
      chk("vec.rf_addr", 128'(rf_addr), 128'(vt[k].rs));
      cycle("vec");
      chk("vec.src_table", out_src_data, vt[k].exp);
      in_valid = 1'b0;
      cycle("vec_idle");
    end
    byp_valid = '0;

    // Skid: A then B while stalled, C offered while full must be ignored.
    out_ready = 1'b0; rand_payload(); in_pc = 64'hA000; in_valid = 1'b1;
    cycle("skid_a");
    rand_payload(); in_pc = 64'hB000;
    cycle("skid_b");
    chk("skid.in_ready_low", 128'(in_ready), 128'd0);
    chk("skid.hold_a", 128'(out_pc), 128'h A000);
    rand_payload(); in_pc = 64'hC000;
    cycle("skid_c_blocked");
    in_valid = 1'b0; out_ready = 1'b1;
    cycle("skid_rel_b");
    chk("skid.then_b", 128'(out_pc), 128'hB000);
    cycle("skid_empty");
    chk("skid.no_dup", 128'(out_valid), 128'd0);

    // Flush while both entries are held.
    out_ready = 1'b0; in_valid = 1'b1; rand_payload();
    cycle("fl_a");
    rand_payload();
    cycle("fl_b");
    flush = 1'b1; rand_payload(); in_pc = 64'hDEAD;
    cycle("fl_flush");
    chk("flush.out_valid", 128'(out_valid), 128'd0);
    chk("flush.in_ready", 128'(in_ready), 128'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) cycle("fl_after");

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      rand_payload();
      in_valid = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 19) == 0);
      in_rs_addr = {5'($urandom_range(0, 6)), 5'($urandom_range(0, 6))};
      byp_valid = 2'($urandom);
      byp_rd = {5'($urandom_range(0, 6)), 5'($urandom_range(0, 6))};
      byp_data = {$urandom, $urandom, $urandom, $urandom};
      rf_data = {$urandom, $urandom, $urandom, $urandom};
      cycle("rand");
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cycle("rand_drain"); cycle("rand_drain");

    // RV32, three sources, no bypass.
    b_rs = {5'd3, 5'd2, 5'd1}; b_rf_data = {32'd3, 32'd2, 32'd1}; b_pc = 32'h1234;
    b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    chk("rv32.out_valid", 128'(b_out_valid), 128'd1);
    chk("rv32.src", 128'(b_src), 128'({32'd3, 32'd2, 32'd1}));
    chk("rv32.pc", 128'(b_out_pc), 128'h1234);

    // Asynchronous reset while in SKID.
    out_ready = 1'b0; in_valid = 1'b1; rand_payload();
    cycle("ar_a");
    rand_payload();
    cycle("ar_b");
    in_valid = 1'b0;
    chk("ar.in_skid", 128'(in_ready), 128'd0);
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    chk("ar.out_valid", 128'(out_valid), 128'd0);
    chk("ar.in_ready", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    cycle("ar_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
